wb_32bit_fifo_reader: RTL

Wishbone slave that pops 32-bit words from a synchronous FIFO read port and returns them on a data bus. It is the read-side counterpart of the FIFO writer used in the wb_fifo testbench environment, and drains the FIFO that the DUT fills. A second Wishbone slave port returns FIFO status: word count, empty flag and a sticky timeout flag. Reads on an empty FIFO wait for data up to a programmable timeout, then end with an error termination.

---
 rtl/wb_32bit_fifo_reader.sv | 93 +++++++++
 1 files changed

// File: rtl/wb_32bit_fifo_reader.sv
// wb_32bit_fifo_reader: Wishbone slave popping 32-bit words from a FIFO read port, plus a status slave.
//   clk_i/rst_i            clock, async active-high reset
//   wbd_*                  data slave: reads pop one FIFO word, writes are acked and ignored, err on timeout
//   wbs_*                  status slave: {timeout_sticky, 0.., rd_num_i, rd_empty_i}
//   rd_dat_i/rd_ena_o/rd_empty_i/rd_num_i  synchronous FIFO read port
module wb_32bit_fifo_reader #(
  parameter int ADR_W   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic [31:0]      wbd_dat_o,
  input  logic             wbd_we_i,
  input  logic             wbd_cyc_i,
  input  logic             wbd_stb_i,
  output logic             wbd_ack_o,
  output logic             wbd_err_o,
  input  logic             wbs_cyc_i,
  input  logic             wbs_stb_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  input  logic [31:0]      rd_dat_i,
  output logic             rd_ena_o,
  input  logic             rd_empty_i,
  input  logic [ADR_W:0]   rd_num_i
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  typedef enum logic [2:0] {IDLE, WAIT, POP, CAPT, ACK_RD, ACK_WR, ERR} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] dat_q, dat_d;
  logic ack_q, ack_d, err_q, err_d, ena_q, ena_d, sack_q, sack_d, tmo_q, tmo_d;
  logic req;
  assign req = wbd_cyc_i & wbd_stb_i;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (req) begin
        if (wbd_we_i) state_d = ACK_WR;
        else if (!rd_empty_i) state_d = POP;
        else begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT:
        if (!req) state_d = IDLE;
        else if (!rd_empty_i) state_d = POP;
        else if (TIMEOUT != 0 && cnt_q == LAST) state_d = ERR;
        else cnt_d = cnt_q + CW'(cnt_q != '1);
      POP:     state_d = CAPT;
      CAPT:    state_d = ACK_RD;
      default: state_d = IDLE;
    endcase
    dat_d  = state_q == CAPT ? rd_dat_i : dat_q;
    ena_d  = state_d == POP;
    ack_d  = state_d == ACK_RD || state_d == ACK_WR;
    err_d  = state_d == ERR;
    // ack spacing: a held strobe yields acks on alternate cycles
    sack_d = wbs_cyc_i & wbs_stb_i & ~sack_q;
    // an error in the same cycle as a status ack keeps the flag set
    tmo_d  = state_q == ERR ? 1'b1 : sack_q ? 1'b0 : tmo_q;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dat_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      ena_q   <= 1'b0;
      sack_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dat_q   <= dat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      ena_q   <= ena_d;
      sack_q  <= sack_d;
      tmo_q   <= tmo_d;
    end
  end
  assign wbd_dat_o = dat_q;
  assign wbd_ack_o = ack_q;
  assign wbd_err_o = err_q;
  assign rd_ena_o  = ena_q;
  assign wbs_ack_o = sack_q;
  assign wbs_dat_o = {tmo_q, {(29 - ADR_W){1'b0}}, rd_num_i, rd_empty_i};
endmodule
